// File: rtl/alarm_pkg.sv
// Shared register map, mode encodings and status-word packing for the
// multi-channel alarm PIO.
package alarm_pkg;

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_MODE  = 2'd1;
   localparam logic [1:0] ADDR_SET   = 2'd2;
   localparam logic [1:0] ADDR_CLEAR = 2'd3;

   localparam logic MODE_STEADY = 1'b0;
   localparam logic MODE_BLINK  = 1'b1;

   // Status word returned when the CLEAR address is read.
   function automatic logic [31:0] status_word(input logic phase, input logic tick);
      return {30'b0, phase, tick};
   endfunction

endpackage

// File: rtl/alarm_blink_timer.sv
// Free-running blink prescaler: counts 0..PRESCALE-1 and toggles phase
// each time the terminal count is reached.
module alarm_blink_timer #(
   parameter int PRESCALE = 25000000
) (
   input  logic clk,
   input  logic reset,
   output logic phase,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

   logic [CW-1:0] r_cnt;
   logic          r_phase;

   assign tick  = (r_cnt == TERM);
   assign phase = r_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (tick) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/alarm_pio_multi.sv
// Avalon-MM multi-channel alarm port: DATA/MODE registers with atomic
// set/clear access, per-channel blink gating and a zero-latency read mux.
import alarm_pkg::*;

module alarm_pio_multi #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 25000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);

   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_mode;
   logic             w_wr;
   logic [WIDTH-1:0] w_wdata;
   logic             w_phase;
   logic             w_tick;
   logic             w_unused_wdata;

   assign w_wr    = chipselect & ~write_n;
   assign w_wdata = writedata[WIDTH-1:0];
   // Bits above the channel count are accepted on the bus and dropped.
   assign w_unused_wdata = ^writedata[31:WIDTH];

   alarm_blink_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .phase (w_phase),
      .tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= '0;
         r_mode <= '0;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:  r_data <= w_wdata;
            ADDR_MODE:  r_mode <= w_wdata;
            ADDR_SET:   r_data <= r_data | w_wdata;
            ADDR_CLEAR: r_data <= r_data & ~w_wdata;
            default:    r_data <= r_data;
         endcase
      end
   end

   // Blinking channels are masked while phase is low; steady ones pass DATA.
   function automatic logic [WIDTH-1:0] gate_out(
      input logic [WIDTH-1:0] data,
      input logic [WIDTH-1:0] mode,
      input logic             phase
   );
      return data & (~mode | {WIDTH{phase}});
   endfunction

   assign out_port = gate_out(r_data, r_mode, w_phase);

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:  readdata = 32'(r_data);
         ADDR_MODE:  readdata = 32'(r_mode);
         ADDR_SET:   readdata = 32'(out_port);
         ADDR_CLEAR: readdata = status_word(w_phase, w_tick);
         default:    readdata = '0;
      endcase
   end

endmodule
